// File: rtl/elastic_config_pkg.sv
// Shared widths, loader state encoding and the context-entry record used by
// the elastic PE configuration loader.
package elastic_config_pkg;

    localparam int DATA_WIDTH                 = 32;
    localparam int OPERATION_BIT_LENGTH       = 4;
    localparam int NEIGHBOR_PE_NUM            = 4;
    localparam int NEIGHBOR_PE_NUM_BIT_LENGTH = 2;
    localparam int CONTEXT_SIZE               = 16;
    localparam int CONTEXT_SIZE_BIT_LENGTH    = 4;
    // One extra bit so a full-depth count (CONTEXT_SIZE) is representable.
    localparam int COUNT_WIDTH                = CONTEXT_SIZE_BIT_LENGTH + 1;

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(CONTEXT_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_e;

    typedef struct packed {
        logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_PE_index_1;
        logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_PE_index_2;
        logic [NEIGHBOR_PE_NUM-1:0]            output_PE_index;
        logic [OPERATION_BIT_LENGTH-1:0]       op;
        logic [DATA_WIDTH-1:0]                 const_data;
    } ElasticConfigData;

endpackage

// File: rtl/elastic_config_loader.sv
// Initiator side of the PE config-load interface: takes a valid/stop entry
// stream, writes one entry per cycle into the PE, then pulses start_exec.
module elastic_config_loader
    import elastic_config_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load_start,
    input  logic [COUNT_WIDTH-1:0]                load_context_count,
    input  logic                                  load_abort,
    input  logic                                  cfg_valid_input,
    output logic                                  cfg_stop_input,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]            cfg_output_PE_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op,
    input  logic [DATA_WIDTH-1:0]                 cfg_const_data,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]            config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic                                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic                                  start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
    output logic                                  busy,
    output logic                                  load_error
);

    // Handshake: an entry transfers on a rising clk edge where
    // cfg_valid_input=1 and cfg_stop_input=0; stop is low only in LOAD.

    loader_state_e                       state_q, state_d;
    logic [COUNT_WIDTH-1:0]              cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]              count_q, count_d;
    ElasticConfigData                    cfg_q, cfg_d;
    logic                                wr_q, wr_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]  idx_q, idx_d;
    logic                                start_q, start_d;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]  max_id_q, max_id_d;
    logic                                err_q, err_d;

    ElasticConfigData                    entry;
    logic [COUNT_WIDTH-1:0]              cnt_inc;
    logic [COUNT_WIDTH-1:0]              count_m1;
    logic                                accept;
    logic                                last_accept;
    logic                                count_bad;

    assign entry.input_PE_index_1 = cfg_input_PE_index_1;
    assign entry.input_PE_index_2 = cfg_input_PE_index_2;
    assign entry.output_PE_index  = cfg_output_PE_index;
    assign entry.op               = cfg_op;
    assign entry.const_data       = cfg_const_data;

    assign cnt_inc     = cnt_q + COUNT_WIDTH'(1);
    assign count_m1    = count_q - COUNT_WIDTH'(1);
    assign accept      = (state_q == ST_LOAD) && cfg_valid_input;
    assign last_accept = accept && (cnt_inc == count_q);
    assign count_bad   = (load_context_count == '0) || (load_context_count > MAX_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            count_q  <= '0;
            cfg_q    <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            start_q  <= 1'b0;
            max_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            cfg_q    <= cfg_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            start_q  <= start_d;
            max_id_q <= max_id_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        cfg_d    = cfg_q;
        wr_d     = 1'b0;
        idx_d    = idx_q;
        start_d  = 1'b0;
        max_id_d = max_id_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (count_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        count_d = load_context_count;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cfg_d = entry;
                    wr_d  = 1'b1;
                    idx_d = cnt_q[CONTEXT_SIZE_BIT_LENGTH-1:0];
                    cnt_d = cnt_inc;
                end
                // Abort still lets a same-cycle entry write, but never starts.
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (last_accept) begin
                    state_d  = ST_START;
                    start_d  = 1'b1;
                    max_id_d = count_m1[CONTEXT_SIZE_BIT_LENGTH-1:0];
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_stop_input          = (state_q != ST_LOAD);
    assign busy                    = (state_q == ST_LOAD) || (state_q == ST_START);
    assign config_input_PE_index_1 = cfg_q.input_PE_index_1;
    assign config_input_PE_index_2 = cfg_q.input_PE_index_2;
    assign config_output_PE_index  = cfg_q.output_PE_index;
    assign config_op               = cfg_q.op;
    assign config_const_data       = cfg_q.const_data;
    assign write_config_data       = wr_q;
    assign config_index            = idx_q;
    assign start_exec              = start_q;
    assign mapping_context_max_id  = max_id_q;
    assign load_error              = err_q;

endmodule
